// File: rtl/decade_seq_ctrl.sv
// Synchronous BCD decade-chain sequencer with start/stop/clear FSM and terminal-count compare.
// Optional DOWN_COUNT_EN adds an up_dn input for down counting with reload from tc.
module decade_seq_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                tick,
    input  logic                oneshot,
`ifdef DOWN_COUNT_EN
    input  logic                up_dn,
`endif
    input  logic [4*DIGITS-1:0] tc,
    output logic [4*DIGITS-1:0] bcd_q,
    output logic                busy,
    output logic                done,
    output logic                wrap,
    output logic                tc_err,
    output logic [1:0]          state_q
);
    localparam int W = 4*DIGITS;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;
    state_t state;

    logic              dn;
    logic [DIGITS-1:0] dig_bad;
    logic [DIGITS-1:0] dig_term;
    logic [DIGITS-1:0] en;
    logic [W-1:0]      step_q;
    logic              tc_bad;
    logic              at_term;
    logic [W-1:0]      load;

`ifdef DOWN_COUNT_EN
    assign dn = ~up_dn;
`else
    assign dn = 1'b0;
`endif

    // Carry/borrow chain: digit i steps only when every lower digit sits at its terminal value.
    assign en[0] = 1'b1;
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [3:0] d;
        assign d           = bcd_q[4*i +: 4];
        assign dig_bad[i]  = tc[4*i +: 4] > 4'd9;
        assign dig_term[i] = dn ? (d == 4'd0) : (d == 4'd9);
        assign step_q[4*i +: 4] = !en[i]      ? d :
                                  dig_term[i] ? (dn ? 4'd9 : 4'd0) :
                                  dn          ? d - 4'd1 : d + 4'd1;
        if (i < DIGITS-1) begin : g_c
            assign en[i+1] = en[i] & dig_term[i];
        end
    end

    // An invalid tc can never equal a valid count in up mode; down mode needs the explicit guard.
    assign tc_bad  = |dig_bad;
    assign at_term = !tc_bad && (dn ? (bcd_q == '0) : (bcd_q == tc));
    assign load    = (dn && !tc_bad) ? tc : '0;
    assign state_q = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            bcd_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            wrap   <= 1'b0;
            tc_err <= 1'b0;
        end else begin
            done   <= 1'b0;
            wrap   <= 1'b0;
            tc_err <= tc_bad;
            if (clear) begin
                state <= IDLE;
                bcd_q <= '0;
                busy  <= 1'b0;
            end else if (stop) begin
                if (state == RUN) begin
                    state <= HOLD;
                    busy  <= 1'b0;
                end
            end else if (start && state != RUN) begin
                state <= RUN;
                busy  <= 1'b1;
                if (state == DONE || (state == IDLE && dn))
                    bcd_q <= load;
            end else if (state == RUN && tick) begin
                if (at_term) begin
                    if (oneshot) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        bcd_q <= load;
                        wrap  <= 1'b1;
                    end
                end else begin
                    bcd_q <= step_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_decade_seq_ctrl.sv
// Directed + randomized bench for decade_seq_ctrl against an integer-valued reference model.
module tb_decade_seq_ctrl;
    localparam int DIGITS = 2;
    localparam int W      = 4*DIGITS;
    localparam int MAX    = 100;
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

    logic         clk = 1'b0;
    logic         reset, start, stop, clear, tick, oneshot;
    logic [W-1:0] tc;
    logic [W-1:0] bcd_q;
    logic         busy, done, wrap, tc_err;
    logic [1:0]   state_q;
`ifdef DOWN_COUNT_EN
    logic         up_dn = 1'b1;
`endif

    decade_seq_ctrl #(.DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .tick(tick), .oneshot(oneshot),
`ifdef DOWN_COUNT_EN
        .up_dn(up_dn),
`endif
        .tc(tc), .bcd_q(bcd_q), .busy(busy), .done(done), .wrap(wrap),
        .tc_err(tc_err), .state_q(state_q)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: count held as a plain integer, state as spec-level names.
    int m_state, m_cnt;
    bit m_done, m_wrap, m_err;

    function automatic int bcd2int(logic [W-1:0] v);
        int acc = 0;
        int p   = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) return -1;
            acc += int'(v[4*i +: 4]) * p;
            p   *= 10;
        end
        return acc;
    endfunction

    function automatic logic [W-1:0] int2bcd(int v);
        logic [W-1:0] r;
        int p = 1;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p *= 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_cnt = 0; m_done = 0; m_wrap = 0; m_err = 0;
    endtask

    task automatic model_step();
        int tcv;
        bit down;
        int term;
        tcv  = bcd2int(tc);
`ifdef DOWN_COUNT_EN
        down = !up_dn;
`else
        down = 0;
`endif
        m_done = 0; m_wrap = 0;
        m_err  = (tcv < 0);
        if (clear) begin
            m_state = M_IDLE; m_cnt = 0;
        end else if (stop) begin
            if (m_state == M_RUN) m_state = M_HOLD;
        end else if (start && m_state != M_RUN) begin
            if (m_state == M_DONE) m_cnt = (down && tcv >= 0) ? tcv : 0;
            if (m_state == M_IDLE && down) m_cnt = (tcv >= 0) ? tcv : 0;
            m_state = M_RUN;
        end else if (m_state == M_RUN && tick) begin
            term = down ? 0 : tcv;
            if (tcv >= 0 && m_cnt == term) begin
                if (oneshot) begin
                    m_state = M_DONE; m_done = 1;
                end else begin
                    m_cnt = down ? tcv : 0; m_wrap = 1;
                end
            end else begin
                m_cnt = down ? (m_cnt + MAX - 1) % MAX : (m_cnt + 1) % MAX;
            end
        end
    endtask

    task automatic check_all(input string tag);
        n_cmp++;
        assert (bcd_q === int2bcd(m_cnt)) else begin
            n_bad++; $error("FAIL %s bcd_q got %h exp %h", tag, bcd_q, int2bcd(m_cnt));
        end
        n_cmp++;
        assert (state_q === 2'(m_state)) else begin
            n_bad++; $error("FAIL %s state_q got %0d exp %0d", tag, state_q, m_state);
        end
        n_cmp++;
        assert (busy === (m_state == M_RUN)) else begin
            n_bad++; $error("FAIL %s busy got %b exp %b", tag, busy, m_state == M_RUN);
        end
        n_cmp++;
        assert (done === m_done) else begin
            n_bad++; $error("FAIL %s done got %b exp %b", tag, done, m_done);
        end
        n_cmp++;
        assert (wrap === m_wrap) else begin
            n_bad++; $error("FAIL %s wrap got %b exp %b", tag, wrap, m_wrap);
        end
        n_cmp++;
        assert (tc_err === m_err) else begin
            n_bad++; $error("FAIL %s tc_err got %b exp %b", tag, tc_err, m_err);
        end
    endtask

    task automatic expect_eq(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    int n_done, n_wrap, n_busy_low;

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        if (done) n_done++;
        if (wrap) n_wrap++;
        if (!busy) n_busy_low++;
    endtask

    task automatic cmd(input logic c, input logic sp, input logic st, input logic tk);
        clear = c; stop = sp; start = st; tick = tk;
    endtask

    initial begin
        logic [W-1:0] tc_set [8];
        tc_set[0] = 8'h00; tc_set[1] = 8'h05; tc_set[2] = 8'h09; tc_set[3] = 8'h12;
        tc_set[4] = 8'h25; tc_set[5] = 8'h99; tc_set[6] = 8'h3A; tc_set[7] = 8'hA0;

        reset = 1'b0; oneshot = 1'b0; tc = 8'h99;
        cmd(0, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b1;

        // One-shot to 0x25: one done pulse, DONE holds tc.
        tc = 8'h25; oneshot = 1'b1;
        cmd(0, 0, 1, 0); step("os_start");
        cmd(0, 0, 0, 1);
        n_done = 0;
        for (int i = 0; i < 40; i++) step("os_run");
        expect_eq("os_done_cnt", n_done, 1);
        expect_eq("os_hold_val", int'(bcd_q), 'h25);
        expect_eq("os_state", int'(state_q), M_DONE);

        // Free-run tc=0x09: two wraps in 24 ticks, busy never drops.
        cmd(1, 0, 0, 0); step("fr_clear");
        tc = 8'h09; oneshot = 1'b0;
        cmd(0, 0, 1, 0); step("fr_start");
        cmd(0, 0, 0, 1);
        n_wrap = 0; n_busy_low = 0;
        for (int i = 0; i < 24; i++) step("fr_run");
        expect_eq("fr_wraps", n_wrap, 2);
        expect_eq("fr_busy_low", n_busy_low, 0);
        expect_eq("fr_final", int'(bcd_q), 'h04);

        // Mid-run asynchronous reset at 0x37.
        tc = 8'h99;
        cmd(1, 0, 0, 0); step("mr_clear");
        cmd(0, 0, 1, 0); step("mr_start");
        cmd(0, 0, 0, 1);
        for (int i = 0; i < 37; i++) step("mr_run");
        expect_eq("mr_at37", int'(bcd_q), 'h37);
        #1 reset = 1'b0;
        #1 model_reset();
        check_all("mr_async");
        #1 reset = 1'b1;

        // stop+tick at 0x19 holds; resume carries into the tens digit.
        cmd(0, 0, 1, 0); step("st_start");
        cmd(0, 0, 0, 1);
        for (int i = 0; i < 19; i++) step("st_run");
        cmd(0, 1, 0, 1); step("st_stop");
        expect_eq("st_hold", int'(bcd_q), 'h19);
        cmd(0, 0, 0, 1); step("st_hold_tick");
        cmd(0, 0, 1, 0); step("st_resume");
        cmd(0, 0, 0, 1); step("st_carry");
        expect_eq("st_carry_val", int'(bcd_q), 'h20);

        // Invalid tc: full-range run with no done/wrap, then clear dominates start+tick.
        tc = 8'h3A; oneshot = 1'b1;
        cmd(1, 0, 0, 0); step("te_clear");
        cmd(0, 0, 1, 0); step("te_start");
        cmd(0, 0, 0, 1);
        n_done = 0; n_wrap = 0;
        for (int i = 0; i < 100; i++) step("te_run");
        expect_eq("te_pulses", n_done + n_wrap, 0);
        expect_eq("te_rollover", int'(bcd_q), 0);
        expect_eq("te_err", int'(tc_err), 1);
        cmd(1, 0, 1, 1); step("te_clr_prio");

`ifdef DOWN_COUNT_EN
        // Down count from 0x12 with reload on reaching 0.
        up_dn = 1'b0; tc = 8'h12; oneshot = 1'b0;
        cmd(1, 0, 0, 0); step("dn_clear");
        cmd(0, 0, 1, 0); step("dn_start");
        cmd(0, 0, 0, 1);
        n_wrap = 0;
        for (int i = 0; i < 14; i++) step("dn_run");
        expect_eq("dn_wraps", n_wrap, 1);
        expect_eq("dn_final", int'(bcd_q), 'h11);
`endif

        // Randomized commands, ticks, mode and terminal count.
        cmd(1, 0, 0, 0); step("rnd_clear");
        for (int i = 0; i < 600; i++) begin
            clear = ($urandom_range(0, 29) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            start = ($urandom_range(0, 4) == 0);
            tick  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) oneshot = ~oneshot;
            if ($urandom_range(0, 39) == 0) tc = tc_set[$urandom_range(0, 7)];
`ifdef DOWN_COUNT_EN
            if ($urandom_range(0, 59) == 0) up_dn = ~up_dn;
`endif
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
